load_store_unit: RTL and testbench

- Sits between the pipeline MEM stage and the word-organised data memory (32-bit words, word address, MemWrite/MemRead strobes, combinational read data `q`).
- Turns byte, halfword and word loads and stores into word accesses.
- Sub-word stores use a read-modify-write sequence.
- Loads are lane-extracted with sign or zero extension, and misaligned or illegal-size accesses are rejected.

---
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-organised data memory.
// Sub-word stores use read-modify-write; lanes are big-endian.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  misaligned,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    write_q, unsigned_q, err_q;
    logic [DATA_WIDTH-1:0]   wdata_q, merge_q, rdata_q;
    logic [DATA_WIDTH-1:0]   load_val, store_word;
    logic [7:0]              lane_b;
    logic [15:0]             lane_h;
    logic                    req_err;

    always_comb begin
        unique case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Lane extraction from the word being read; offset 0 is the MSB lane.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    lane_b = mem_q[31:24];
            2'd1:    lane_b = mem_q[23:16];
            2'd2:    lane_b = mem_q[15:8];
            default: lane_b = mem_q[7:0];
        endcase
        lane_h = addr_q[1] ? mem_q[15:0] : mem_q[31:16];
        unique case (size_q)
            2'b00:   load_val = unsigned_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = unsigned_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = mem_q;
        endcase
    end

    always_comb begin
        store_word = merge_q;
        unique case (size_q)
            2'b00: begin
                unique case (addr_q[1:0])
                    2'd0:    store_word[31:24] = wdata_q[7:0];
                    2'd1:    store_word[23:16] = wdata_q[7:0];
                    2'd2:    store_word[15:8]  = wdata_q[7:0];
                    default: store_word[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) store_word[15:0]  = wdata_q[15:0];
                else           store_word[31:16] = wdata_q[15:0];
            end
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (req_err)                             state_d = StResp;
                    else if (req_write && req_size == 2'b10) state_d = StWr;
                    else                                     state_d = StRd;
                end
            end
            StRd:    state_d = write_q ? StWr : StResp;
            StWr:    state_d = StResp;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req) begin
                addr_q     <= req_addr;
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                err_q      <= req_err;
                wdata_q    <= req_wdata;
            end
            if (state_q == StRd) begin
                merge_q <= mem_q;
                if (!write_q) rdata_q <= load_val;
            end
        end
    end

    always_comb begin
        ready      = (state_q == StIdle);
        done       = (state_q == StResp);
        misaligned = done & err_q;
        MemRead    = (state_q == StRd);
        MemWrite   = (state_q == StWr);
        mem_addr   = addr_q[ADDR_WIDTH+1:2];
        mem_data   = MemWrite ? store_word : '0;
        rdata      = rdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset, req, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        ready, done, misaligned, MemWrite, MemRead;
    logic [31:0] rdata, mem_data, mem_q;
    logic [5:0]  mem_addr;

    logic [31:0] mem [64];

    typedef struct {
        logic        mis;
        logic [31:0] rd;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int          checks = 0, errors = 0, cyc = 0;
    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int          wr0, rd0, d0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] last_rd = '0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ready        (ready),
        .done         (done),
        .misaligned   (misaligned),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .mem_q        (mem_q)
    );

    always #5 clk = ~clk;

    assign mem_q = mem[mem_addr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (MemWrite) mem[mem_addr] <= mem_data;
    end

    always @(negedge clk) begin
        if (MemWrite) begin
            wr_cnt++;
            wr_addr = mem_addr;
        end
        if (MemRead) rd_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                e = sb.pop_front();
                check("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                check("rdata", rdata, e.rd);
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                         input logic [31:0] wd, input logic push, input logic emis,
                         input logic [31:0] ld_val, input int lat);
        exp_t x;
        int n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1");
        end
        req = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        if (!w && !emis) last_rd = ld_val;
        x.mis = emis; x.rd = last_rd; x.acc = cyc; x.lat = lat;
        if (push) sb.push_back(x);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 10);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=0 expected done=1", name);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset = 1'b1; req = 1'b0; req_write = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        settle();

        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_strobes", {30'b0, MemRead, MemWrite}, 32'd0);
        check("rst_mem_addr", {26'b0, mem_addr}, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);

        wr0 = wr_cnt;
        start(1'b1, 2'b10, 1'b0, 8'h10, 32'h12345678, 1'b1, 1'b0, '0, 2);
        wait_done("word_store");
        settle();
        check("ws_mem", mem[4], 32'h12345678);
        check("ws_wr_cnt", wr_cnt - wr0, 32'd1);
        check("ws_wr_addr", {26'b0, wr_addr}, 32'd4);

        start(1'b0, 2'b10, 1'b0, 8'h10, '0, 1'b1, 1'b0, 32'h12345678, 2);
        wait_done("word_load");

        start(1'b1, 2'b00, 1'b0, 8'h11, 32'h000000AB, 1'b1, 1'b0, '0, 3);
        wait_done("byte_store");
        settle();
        check("bs_mem", mem[4], 32'h12AB5678);
        start(1'b0, 2'b00, 1'b0, 8'h11, '0, 1'b1, 1'b0, 32'hFFFFFFAB, 2);
        wait_done("byte_load_s");
        start(1'b0, 2'b00, 1'b1, 8'h11, '0, 1'b1, 1'b0, 32'h000000AB, 2);
        wait_done("byte_load_u");

        start(1'b1, 2'b01, 1'b0, 8'h12, 32'h0000BEEF, 1'b1, 1'b0, '0, 3);
        wait_done("half_store");
        settle();
        check("hs_mem", mem[4], 32'h12ABBEEF);
        start(1'b0, 2'b01, 1'b0, 8'h12, '0, 1'b1, 1'b0, 32'hFFFFBEEF, 2);
        wait_done("half_load_s");
        start(1'b0, 2'b01, 1'b1, 8'h10, '0, 1'b1, 1'b0, 32'h000012AB, 2);
        wait_done("half_load_u");

        settle();
        wr0 = wr_cnt; rd0 = rd_cnt;
        start(1'b0, 2'b10, 1'b0, 8'h13, '0, 1'b1, 1'b1, '0, 1);
        wait_done("rej_word_load");
        start(1'b1, 2'b01, 1'b0, 8'h11, 32'h00001111, 1'b1, 1'b1, '0, 1);
        wait_done("rej_half_store");
        start(1'b1, 2'b11, 1'b0, 8'h10, 32'h22222222, 1'b1, 1'b1, '0, 1);
        wait_done("rej_size11");
        settle();
        check("rej_wr_cnt", wr_cnt - wr0, 32'd0);
        check("rej_rd_cnt", rd_cnt - rd0, 32'd0);
        check("rej_mem", mem[4], 32'h12ABBEEF);

        // Busy-time req must be dropped; the following req is back-to-back.
        d0 = done_cnt;
        start(1'b1, 2'b00, 1'b0, 8'h13, 32'h000000CD, 1'b1, 1'b0, '0, 3);
        req = 1'b1; req_write = 1'b0; req_size = 2'b11; req_addr = 8'h10;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 req = 1'b0;
        wait_done("busy_store");
        start(1'b0, 2'b10, 1'b0, 8'h10, '0, 1'b1, 1'b0, 32'h12ABBECD, 2);
        wait_done("b2b_load");
        settle();
        settle();
        check("busy_done_cnt", done_cnt - d0, 32'd2);
        check("busy_mem", mem[4], 32'h12ABBECD);

        wr0 = wr_cnt; d0 = done_cnt;
        start(1'b1, 2'b00, 1'b0, 8'h10, 32'h00000055, 1'b0, 1'b0, '0, 3);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        last_rd = '0;
        settle();
        check("mid_rst_ready", {31'b0, ready}, 32'd1);
        check("mid_rst_rdata", rdata, 32'd0);
        repeat (3) settle();
        check("mid_rst_wr_cnt", wr_cnt - wr0, 32'd0);
        check("mid_rst_done_cnt", done_cnt - d0, 32'd0);
        check("mid_rst_mem", mem[4], 32'h12ABBECD);

        start(1'b0, 2'b00, 1'b1, 8'h13, '0, 1'b1, 1'b0, 32'h000000CD, 2);
        wait_done("post_rst_load");
        settle();
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
